// File: rtl/fp_pack_pkg.sv
// Shared definitions for the FP pack stage.
//   - rounding-mode encodings carried on the rm port
//   - bit positions inside flags_out {nv, of, uf, nx} and class_out {nan, pinf, ninf}
//   - exponent bias and largest-finite-magnitude helpers, derived from the format widths
package fp_pack_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam int CLS_NAN  = 2;
  localparam int CLS_PINF = 1;
  localparam int CLS_NINF = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Magnitude (exponent and fraction, no sign) of the largest finite value.
  function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
    logic [63:0] e_max;
    e_max = (64'd1 << exp_w) - 64'd2;
    return (e_max << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round_encode.sv
// Combinational round / range-check / encode of one normalised value.
//   sign_in, exp_in (signed, unbiased), mant_in {hidden, fraction, G, R, S}
//   is_nan_in, is_pinf_in, is_ninf_in : special classes (priority nan > pinf > ninf)
//   rm        : rounding mode
//   data_out  : {sign, exponent, fraction}
//   class_out : {nan, pinf, ninf}
//   flags_out : {nv, of, uf, nx}
module fp_round_encode
  import fp_pack_pkg::*;
#(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int IN_EXP_W = 7
) (
  input  logic                       sign_in,
  input  logic signed [IN_EXP_W-1:0] exp_in,
  input  logic [MAN_W+3:0]           mant_in,
  input  logic                       is_nan_in,
  input  logic                       is_pinf_in,
  input  logic                       is_ninf_in,
  input  logic [1:0]                 rm,
  output logic [EXP_W+MAN_W:0]       data_out,
  output logic [2:0]                 class_out,
  output logic [3:0]                 flags_out
);

  localparam int OUT_W = 1 + EXP_W + MAN_W;
  // One extra bit so exponent + bias + carry cannot wrap.
  localparam int EB_W  = IN_EXP_W + 1;

  localparam logic signed [EB_W-1:0] BIAS_S  = EB_W'(fp_bias(EXP_W));
  localparam logic signed [EB_W-1:0] EB_OVF  = EB_W'((1 << EXP_W) - 1);
  localparam logic signed [EB_W-1:0] EB_ZERO = '0;
  localparam logic [OUT_W-2:0]       MAX_MAG = (OUT_W-1)'(fp_max_finite(EXP_W, MAN_W));
  localparam logic [OUT_W-2:0]       INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [OUT_W-1:0]       QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic round_inc(input logic [1:0] mode, input logic s,
                                     input logic lsb, input logic g, input logic rs);
    logic inc;
    case (mode)
      RM_RNE:  inc = g & (rs | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~s & (g | rs);
      default: inc = s & (g | rs);
    endcase
    return inc;
  endfunction

  // Overflow saturates to infinity only when the mode rounds away from zero
  // in the direction of the sign; otherwise it clamps to the largest finite.
  function automatic logic [OUT_W-1:0] ovf_result(input logic [1:0] mode, input logic s);
    logic to_inf;
    to_inf = (mode == RM_RNE) | ((mode == RM_RUP) & ~s) | ((mode == RM_RDN) & s);
    return {s, to_inf ? INF_MAG : MAX_MAG};
  endfunction

  logic [MAN_W:0]          sig;
  logic [MAN_W+1:0]        sum;
  logic                    lsb, g, rs, inc, carry;
  logic [MAN_W-1:0]        frac;
  logic signed [EB_W-1:0]  exp_ext, carry_ext, e_b;

  assign sig       = mant_in[MAN_W+3:3];
  assign lsb       = mant_in[3];
  assign g         = mant_in[2];
  assign rs        = mant_in[1] | mant_in[0];
  assign inc       = round_inc(rm, sign_in, lsb, g, rs);
  assign sum       = {1'b0, sig} + (MAN_W+2)'(inc);
  assign carry     = sum[MAN_W+1];
  assign frac      = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign exp_ext   = {exp_in[IN_EXP_W-1], exp_in};
  assign carry_ext = {{(EB_W-1){1'b0}}, carry};
  assign e_b       = exp_ext + BIAS_S + carry_ext;

  always_comb begin
    data_out  = '0;
    class_out = '0;
    flags_out = '0;
    if (is_nan_in) begin
      data_out          = QNAN;
      class_out[CLS_NAN] = 1'b1;
      flags_out[FLG_NV] = 1'b1;
    end else if (is_pinf_in) begin
      data_out            = {1'b0, INF_MAG};
      class_out[CLS_PINF] = 1'b1;
    end else if (is_ninf_in) begin
      data_out            = {1'b1, INF_MAG};
      class_out[CLS_NINF] = 1'b1;
    end else if (!mant_in[MAN_W+3]) begin
      data_out = {sign_in, {(OUT_W-1){1'b0}}};
    end else if (e_b >= EB_OVF) begin
      data_out          = ovf_result(rm, sign_in);
      flags_out[FLG_OF] = 1'b1;
      flags_out[FLG_NX] = 1'b1;
    end else if (e_b <= EB_ZERO) begin
      // No subnormal output: anything below the normal range flushes to zero.
      data_out          = {sign_in, {(OUT_W-1){1'b0}}};
      flags_out[FLG_UF] = 1'b1;
      flags_out[FLG_NX] = 1'b1;
    end else begin
      data_out          = {sign_in, e_b[EXP_W-1:0], frac};
      flags_out[FLG_NX] = g | rs;
    end
  end

endmodule

// File: rtl/fp_pack_stage.sv
// Tail stage of the FP pipeline: rounds and encodes each accepted item and
// presents it through a valid/ready interface backed by a 2-entry skid buffer
// (output register + skid entry), so in_ready never depends on out_ready.
//   clk, rst_n (async, active-low), enable (0 freezes everything), flush
//   rm, in_valid/in_ready, sign_in, exp_in, mant_in, is_*_in, tag_in : upstream
//   out_valid/out_ready, out_data, class_out, flags_out, tag_out      : downstream
module fp_pack_stage
  import fp_pack_pkg::*;
#(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int IN_EXP_W = 7,
  parameter int TAG_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [1:0]                 rm,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sign_in,
  input  logic signed [IN_EXP_W-1:0] exp_in,
  input  logic [MAN_W+3:0]           mant_in,
  input  logic                       is_nan_in,
  input  logic                       is_pinf_in,
  input  logic                       is_ninf_in,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_data,
  output logic [2:0]                 class_out,
  output logic [3:0]                 flags_out,
  output logic [TAG_W-1:0]           tag_out
);

  localparam int OUT_W = 1 + EXP_W + MAN_W;
  localparam int ENT_W = OUT_W + 3 + 4 + TAG_W;

  logic [OUT_W-1:0] enc_data_p0;
  logic [2:0]       enc_cls_p0;
  logic [3:0]       enc_flg_p0;
  logic [ENT_W-1:0] ent_p0;
  logic [ENT_W-1:0] out_p1, skid_p1;
  logic             vld_p1, skid_vld_p1;
  logic             accept, xfer;

  // p0: round and encode the incoming item; rm is consumed here, so the
  // mode in force at accept time is what ends up in the stored result.
  fp_round_encode #(
    .EXP_W   (EXP_W),
    .MAN_W   (MAN_W),
    .IN_EXP_W(IN_EXP_W)
  ) u_round_encode (
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .is_nan_in (is_nan_in),
    .is_pinf_in(is_pinf_in),
    .is_ninf_in(is_ninf_in),
    .rm        (rm),
    .data_out  (enc_data_p0),
    .class_out (enc_cls_p0),
    .flags_out (enc_flg_p0)
  );

  assign ent_p0   = {enc_data_p0, enc_cls_p0, enc_flg_p0, tag_in};
  assign in_ready = enable & ~skid_vld_p1;
  assign accept   = in_valid & in_ready;
  assign xfer     = vld_p1 & out_ready & enable;

  // p1: output register and skid entry. The skid only fills when the output
  // register is occupied and not draining, and it always drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (enable) begin
      if (flush) begin
        vld_p1      <= 1'b0;
        skid_vld_p1 <= 1'b0;
      end else if (xfer) begin
        if (skid_vld_p1) begin
          out_p1      <= skid_p1;
          skid_vld_p1 <= 1'b0;
        end else if (accept) begin
          out_p1 <= ent_p0;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (accept) begin
        if (!vld_p1) begin
          out_p1 <= ent_p0;
          vld_p1 <= 1'b1;
        end else begin
          skid_p1     <= ent_p0;
          skid_vld_p1 <= 1'b1;
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign {out_data, class_out, flags_out, tag_out} = out_p1;

endmodule

// File: tb/tb_fp_pack_stage.sv
module tb_fp_pack_stage;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int IN_EXP_W = 7;
  localparam int TAG_W    = 4;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       enable = 1'b0;
  logic                       flush = 1'b0;
  logic [1:0]                 rm = 2'd0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic                       sign_in = 1'b0;
  logic signed [IN_EXP_W-1:0] exp_in = '0;
  logic [MAN_W+3:0]           mant_in = '0;
  logic                       is_nan_in = 1'b0;
  logic                       is_pinf_in = 1'b0;
  logic                       is_ninf_in = 1'b0;
  logic [TAG_W-1:0]           tag_in = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [EXP_W+MAN_W:0]       out_data;
  logic [2:0]                 class_out;
  logic [3:0]                 flags_out;
  logic [TAG_W-1:0]           tag_out;

  int n_pass  = 0;
  int n_total = 0;

  fp_pack_stage #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .IN_EXP_W(IN_EXP_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .rm(rm),
    .in_valid(in_valid), .in_ready(in_ready), .sign_in(sign_in), .exp_in(exp_in),
    .mant_in(mant_in), .is_nan_in(is_nan_in), .is_pinf_in(is_pinf_in),
    .is_ninf_in(is_ninf_in), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .class_out(class_out),
    .flags_out(flags_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  cls;
    logic [3:0]  flg;
    logic [3:0]  tag;
  } res_t;

  // Reference: value = 1.frac * 2^e with a 3-bit remainder below the lsb,
  // rounded by comparing the remainder against one half.
  function automatic res_t model(input logic s, input int e, input int mant,
                                 input logic nan, input logic pinf, input logic ninf,
                                 input logic [1:0] mode, input logic [3:0] tag);
    res_t r;
    int sig, rem, eb;
    logic up, to_inf;
    r = '0;
    r.tag = tag;
    if (nan) begin
      r.data = 16'h7E00; r.cls = 3'b100; r.flg = 4'b1000;
    end else if (pinf) begin
      r.data = 16'h7C00; r.cls = 3'b010;
    end else if (ninf) begin
      r.data = 16'hFC00; r.cls = 3'b001;
    end else if (mant < 8192) begin
      r.data = {s, 15'h0};
    end else begin
      sig = mant / 8;
      rem = mant % 8;
      eb  = e + 15;
      case (mode)
        2'd0:    up = (rem > 4) || (rem == 4 && (sig % 2) == 1);
        2'd1:    up = 1'b0;
        2'd2:    up = !s && rem != 0;
        default: up = s && rem != 0;
      endcase
      r.flg[0] = (rem != 0);
      sig = sig + int'(up);
      if (sig == 2048) begin
        sig = 1024;
        eb  = eb + 1;
      end
      if (eb >= 31) begin
        to_inf = (mode == 2'd0) || (mode == 2'd2 && !s) || (mode == 2'd3 && s);
        r.data = to_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
        r.flg  = 4'b0101;
      end else if (eb <= 0) begin
        r.data = {s, 15'h0};
        r.flg  = 4'b0011;
      end else begin
        r.data = {s, 5'(eb), 10'(sig)};
      end
    end
    return r;
  endfunction

  task automatic drive(input logic s, input int e, input int mant, input logic nan,
                       input logic pinf, input logic ninf, input logic [1:0] mode,
                       input logic [3:0] tag);
    sign_in = s; exp_in = 7'(e); mant_in = 14'(mant);
    is_nan_in = nan; is_pinf_in = pinf; is_ninf_in = ninf; rm = mode; tag_in = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if ({out_data, class_out, flags_out, tag_out} !== 27'h0)
      $display("FAIL reset_outputs: got %h want 0", {out_data, class_out, flags_out, tag_out});
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic s; int e; int mant; logic nan; logic [1:0] mode;
    logic [15:0] data; logic [3:0] flg; logic [2:0] cls;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    v[0] = '{1'b0,   0, 'h2000, 1'b0, 2'd0, 16'h3C00, 4'h0, 3'b000};
    v[1] = '{1'b0,   0, 'h200C, 1'b0, 2'd0, 16'h3C02, 4'h1, 3'b000};
    v[2] = '{1'b0,   0, 'h200C, 1'b0, 2'd1, 16'h3C01, 4'h1, 3'b000};
    v[3] = '{1'b0,   0, 'h3FFC, 1'b0, 2'd0, 16'h4000, 4'h1, 3'b000};
    v[4] = '{1'b0,  16, 'h2000, 1'b0, 2'd0, 16'h7C00, 4'h5, 3'b000};
    v[5] = '{1'b0,  16, 'h2000, 1'b0, 2'd1, 16'h7BFF, 4'h5, 3'b000};
    v[6] = '{1'b1,  16, 'h2000, 1'b0, 2'd2, 16'hFBFF, 4'h5, 3'b000};
    v[7] = '{1'b1, -15, 'h2000, 1'b0, 2'd0, 16'h8000, 4'h3, 3'b000};
    v[8] = '{1'b1,   5, 'h1234, 1'b1, 2'd3, 16'h7E00, 4'h8, 3'b100};
    v[9] = '{1'b1,   3, 'h0000, 1'b0, 2'd2, 16'h8000, 4'h0, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(v[i].s, v[i].e, v[i].mant, v[i].nan, 1'b0, 1'b0, v[i].mode, 4'(i));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_total++;
      if ({out_valid, out_data, flags_out, class_out, tag_out} !==
          {1'b1, v[i].data, v[i].flg, v[i].cls, 4'(i)})
        $display("FAIL directed_%0d: got v=%b d=%h f=%h c=%b t=%h want d=%h f=%h c=%b", i,
                 out_valid, out_data, flags_out, class_out, tag_out, v[i].data, v[i].flg, v[i].cls);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t want;
    int k;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, 19);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)) - 20,
            ($urandom_range(0, 15) == 0) ? 0 : int'(14'h2000 | $urandom_range(0, 'h1FFF)),
            k == 0 || k == 3, k == 1 || k == 3, k == 2,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready)
        q.push_back(model(sign_in, int'(exp_in), int'(mant_in), is_nan_in, is_pinf_in,
                          is_ninf_in, rm, tag_in));
      if (out_valid && out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL random_extra: got %h want nothing", out_data);
        else begin
          want = q.pop_front();
          if ({out_data, class_out, flags_out, tag_out} !== want)
            $display("FAIL random_item: got %h want %h",
                     {out_data, class_out, flags_out, tag_out}, want);
          else n_pass++;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_total++;
        if (q.size() == 0) $display("FAIL drain_extra: got %h want nothing", out_data);
        else begin
          want = q.pop_front();
          if ({out_data, class_out, flags_out, tag_out} !== want)
            $display("FAIL drain_item: got %h want %h",
                     {out_data, class_out, flags_out, tag_out}, want);
          else n_pass++;
        end
      end
      tick();
    end
    n_total++;
    if (q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL random_lost: got %0d pending valid=%b want 0", q.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    out_ready = 1'b0;
    drive(1'b0, 0, 'h2000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1);
    in_valid = 1'b1;
    tick();
    drive(1'b0, 1, 'h2000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h2);
    tick();
    drive(1'b0, 2, 'h2000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h3);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_skid_full: got in_ready=%b want 0", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({out_valid, out_data, in_ready} !== {1'b1, 16'h3C00, 1'b0})
      $display("FAIL b2b_hold: got v=%b d=%h r=%b want v=1 d=3c00 r=0", out_valid, out_data, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else tick();
    end
    n_total++;
    if (got.size() != 3) $display("FAIL b2b_count: got %0d want 3", got.size());
    else begin
      n_pass++;
      n_total++;
      if (got[0] !== 16'h3C00) $display("FAIL b2b_A: got %h want 3c00", got[0]); else n_pass++;
      n_total++;
      if (got[1] !== 16'h4000) $display("FAIL b2b_B: got %h want 4000", got[1]); else n_pass++;
      n_total++;
      if (got[2] !== 16'h4400) $display("FAIL b2b_C: got %h want 4400", got[2]); else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_enable_freeze();
    out_ready = 1'b0;
    drive(1'b0, 0, 'h2000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h5);
    in_valid = 1'b1;
    tick();
    enable = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1, 'h2000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, out_data, tag_out, in_ready} !== {1'b1, 16'h3C00, 4'h5, 1'b0})
        $display("FAIL freeze_%0d: got v=%b d=%h t=%h r=%b want v=1 d=3c00 t=5 r=0",
                 c, out_valid, out_data, tag_out, in_ready);
      else n_pass++;
      tick();
    end
    enable = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, out_data, tag_out} !== {1'b1, 16'h4000, 4'h6})
      $display("FAIL unfreeze_next: got v=%b d=%h t=%h want v=1 d=4000 t=6", out_valid, out_data, tag_out);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL unfreeze_empty: got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b0, 0, 'h2000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h7);
    in_valid = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    n_total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush_clear: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    else n_pass++;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_accept_dropped: got %b want 0", out_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 16, 'h2000, 1'b0, 1'b0, 1'b0, 2'd1, 4'hF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_data, class_out, flags_out, tag_out} !== 28'h0)
      $display("FAIL reset_mid: got %h want 0", {out_valid, out_data, class_out, flags_out, tag_out});
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_mid_after: got %b want 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_enable_freeze();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
